core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32 core. Generates the 3-bit `state` bus consumed by the ALU, register file and PC logic. Handshakes with the instruction-fetch port and the data-memory port. Stretches EXECUTE for M-extension ops so the ALU's muldiv path gets a fixed number of cycles. Sits between the decoder (instruction class flags) and the ALU/regfile/PC enables.

---
 rtl/core_sequencer.sv | 126 ++++++++++++
 tb/tb_core_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the RV32 core.
// Drives the state bus and the fetch/memory handshakes; every strobe is a
// combinational decode of the registered state plus the live inputs.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH    0 | fetch_req high, waiting for fetch_ready
// DECODE   1 | one cycle; illegal -> HALT, else arm EXECUTE timer
// EXECUTE  2 | ALU/muldiv working; leaves when the timer reaches zero
// MEM      3 | mem_req high, waiting for mem_ready
// WRITEBACK 4| one cycle; rf/pc strobes, retire counter increments
// HALT     5 | absorbing until reset
module core_sequencer #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_req,
  input  logic             fetch_ready,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_muldiv,
  input  logic             writes_rd,
  input  logic             illegal,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halted,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // Timer load value: EXECUTE lasts EX_LAST+1 cycles for muldiv ops.
  // MULDIV_CYCLES of 0 and 1 both collapse to a single cycle.
  localparam int              EX_LAST = (MULDIV_CYCLES > 1) ? MULDIV_CYCLES - 1 : 0;
  localparam int              EX_W    = (EX_LAST > 1) ? $clog2(EX_LAST + 1) : 1;
  localparam logic [EX_W-1:0] EX_LOAD = EX_W'(EX_LAST);

  state_t          state_q;
  state_t          state_d;
  logic [EX_W-1:0] cnt_q;
  logic [EX_W-1:0] cnt_d;

  // State register and EXECUTE down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the EXECUTE timer exits on terminal count zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (fetch_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
          cnt_d   = is_muldiv ? EX_LOAD : '0;
        end
      end
      S_EXECUTE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (mem_ready) state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
    end else if (state_q == S_WRITEBACK) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign fetch_req = (state_q == S_FETCH);
  assign ir_we     = fetch_req & fetch_ready;
  assign mem_req   = (state_q == S_MEM);
  assign mem_we    = mem_req & is_store;
  assign rf_we     = (state_q == S_WRITEBACK) & writes_rd;
  assign pc_we     = (state_q == S_WRITEBACK);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: three instances (MULDIV_CYCLES 4/0/1) share the
// same inputs; a cycle-level reference model per instance is compared at
// every falling edge, and directed sequences pin literal state traces.
module tb_core_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_ready = 1'b0;
  logic mem_ready = 1'b0;
  logic is_load = 1'b0;
  logic is_store = 1'b0;
  logic is_muldiv = 1'b0;
  logic writes_rd = 1'b0;
  logic illegal = 1'b0;

  logic [2:0][2:0] st;
  logic [2:0] fq, irw, mrq, mwe, rfw, pcw, hlt;
  logic [3:0]  rc0;
  logic [31:0] rc1;
  logic [7:0]  rc2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_sequencer #(.MULDIV_CYCLES(4), .CNT_W(4)) u_seq0 (
    .clk(clk), .rst(rst), .fetch_req(fq[0]), .fetch_ready(fetch_ready),
    .mem_req(mrq[0]), .mem_we(mwe[0]), .mem_ready(mem_ready),
    .is_load(is_load), .is_store(is_store), .is_muldiv(is_muldiv),
    .writes_rd(writes_rd), .illegal(illegal), .state(st[0]),
    .ir_we(irw[0]), .rf_we(rfw[0]), .pc_we(pcw[0]), .halted(hlt[0]),
    .retire_count(rc0));

  core_sequencer #(.MULDIV_CYCLES(0), .CNT_W(32)) u_seq1 (
    .clk(clk), .rst(rst), .fetch_req(fq[1]), .fetch_ready(fetch_ready),
    .mem_req(mrq[1]), .mem_we(mwe[1]), .mem_ready(mem_ready),
    .is_load(is_load), .is_store(is_store), .is_muldiv(is_muldiv),
    .writes_rd(writes_rd), .illegal(illegal), .state(st[1]),
    .ir_we(irw[1]), .rf_we(rfw[1]), .pc_we(pcw[1]), .halted(hlt[1]),
    .retire_count(rc1));

  core_sequencer #(.MULDIV_CYCLES(1), .CNT_W(8)) u_seq2 (
    .clk(clk), .rst(rst), .fetch_req(fq[2]), .fetch_ready(fetch_ready),
    .mem_req(mrq[2]), .mem_we(mwe[2]), .mem_ready(mem_ready),
    .is_load(is_load), .is_store(is_store), .is_muldiv(is_muldiv),
    .writes_rd(writes_rd), .illegal(illegal), .state(st[2]),
    .ir_we(irw[2]), .rf_we(rfw[2]), .pc_we(pcw[2]), .halted(hlt[2]),
    .retire_count(rc2));

  function automatic logic [63:0] rc_of(input int i);
    case (i)
      0:       return 64'(rc0);
      1:       return 64'(rc1);
      default: return 64'(rc2);
    endcase
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, idx, $time, act, exp);
  endtask

  // Reference model: phase numbers are the architectural state values.
  // EXECUTE length is tracked as "cycles spent vs cycles owed".
  int          mcyc [3] = '{4, 0, 1};
  int          rw   [3] = '{4, 32, 8};
  int          ph   [3] = '{0, 0, 0};
  int          ex_spent [3] = '{0, 0, 0};
  int          ex_owed  [3] = '{1, 1, 1};
  logic [63:0] ret  [3] = '{64'd0, 64'd0, 64'd0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ph[i]  <= 0;
        ret[i] <= 64'd0;
      end else begin
        case (ph[i])
          0: if (fetch_ready) ph[i] <= 1;
          1: begin
            if (illegal) ph[i] <= 5;
            else begin
              ph[i]       <= 2;
              ex_spent[i] <= 0;
              ex_owed[i]  <= is_muldiv ? ((mcyc[i] > 1) ? mcyc[i] : 1) : 1;
            end
          end
          2: begin
            ex_spent[i] <= ex_spent[i] + 1;
            if (ex_spent[i] + 1 >= ex_owed[i]) ph[i] <= (is_load || is_store) ? 3 : 4;
          end
          3: if (mem_ready) ph[i] <= 4;
          4: begin
            ret[i] <= (ret[i] + 64'd1) & ((64'd1 << rw[i]) - 64'd1);
            ph[i]  <= 0;
          end
          default: ph[i] <= ph[i];
        endcase
      end
    end
  end

  // Every falling edge: all outputs of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("state",     i, 64'(st[i]),  64'(ph[i]));
      chk("fetch_req", i, 64'(fq[i]),  64'(ph[i] == 0));
      chk("ir_we",     i, 64'(irw[i]), 64'(ph[i] == 0 && fetch_ready));
      chk("mem_req",   i, 64'(mrq[i]), 64'(ph[i] == 3));
      chk("mem_we",    i, 64'(mwe[i]), 64'(ph[i] == 3 && is_store));
      chk("rf_we",     i, 64'(rfw[i]), 64'(ph[i] == 4 && writes_rd));
      chk("pc_we",     i, 64'(pcw[i]), 64'(ph[i] == 4));
      chk("halted",    i, 64'(hlt[i]), 64'(ph[i] == 5));
      chk("retire",    i, rc_of(i),    ret[i]);
    end
  end

  int c_fr, c_ir, c_mreq, c_mwe, c_rf, c_pc, c_halt;
  int ex_cnt [3];

  // Runs a fixed input schedule; exp holds the literal state trace of instance 0.
  task automatic run_seq(input string exp, input logic ld, input logic sto, input logic md,
                         input logic wr, input logic ill, input int fr_at, input int mr_at);
    c_fr = 0; c_ir = 0; c_mreq = 0; c_mwe = 0; c_rf = 0; c_pc = 0; c_halt = 0;
    for (int k = 0; k < 3; k++) ex_cnt[k] = 0;
    is_load = ld; is_store = sto; is_muldiv = md; writes_rd = wr; illegal = ill;
    for (int i = 0; i < exp.len(); i++) begin
      fetch_ready = (i == fr_at);
      mem_ready   = (i == mr_at);
      @(negedge clk);
      chk("trace", i, 64'(st[0]), 64'(int'(exp[i]) - 48));
      c_fr += int'(fq[0]); c_ir += int'(irw[0]); c_mreq += int'(mrq[0]);
      c_mwe += int'(mwe[0]); c_rf += int'(rfw[0]); c_pc += int'(pcw[0]);
      c_halt += int'(hlt[0]);
      for (int k = 0; k < 3; k++) if (st[k] == 3'd2) ex_cnt[k]++;
      @(posedge clk); #1;
    end
    fetch_ready = 1'b0;
    mem_ready   = 1'b0;
    illegal     = 1'b0;
  endtask

  initial begin
    string s;
    logic  do_rst;

    @(negedge clk);
    chk("rst_state", 0, 64'(st[0]), 64'd0);
    chk("rst_fetch_req", 0, 64'(fq[0]), 64'd1);
    chk("rst_retire", 0, rc_of(0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD, fetch completes on the third FETCH cycle
    run_seq("0001240", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, -1);
    chk("add_ir_we", 0, 64'(c_ir), 64'd1);
    chk("add_rf_we", 0, 64'(c_rf), 64'd1);
    chk("add_pc_we", 0, 64'(c_pc), 64'd1);
    chk("add_retire", 0, rc_of(0), 64'd1);

    // LW, mem_ready on the third MEM cycle
    run_seq("01233340", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 5);
    chk("lw_mem_req", 0, 64'(c_mreq), 64'd3);
    chk("lw_mem_we", 0, 64'(c_mwe), 64'd0);
    chk("lw_rf_we", 0, 64'(c_rf), 64'd1);
    chk("lw_retire", 0, rc_of(0), 64'd2);

    // SW, zero-wait memory, no rd write
    run_seq("012340", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
    chk("sw_mem_we", 0, 64'(c_mwe), 64'd1);
    chk("sw_rf_we", 0, 64'(c_rf), 64'd0);
    chk("sw_pc_we", 0, 64'(c_pc), 64'd1);
    chk("sw_retire", 0, rc_of(0), 64'd3);

    // DIV: EXECUTE 4 cycles at MULDIV_CYCLES=4, 1 cycle at 0 and 1
    run_seq("01222240", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, -1);
    chk("div_ex_m4", 0, 64'(ex_cnt[0]), 64'd4);
    chk("div_ex_m0", 1, 64'(ex_cnt[1]), 64'd1);
    chk("div_ex_m1", 2, 64'(ex_cnt[2]), 64'd1);
    chk("div_retire", 1, rc_of(1), 64'd4);

    // Reset between edges in the middle of a load's MEM phase
    run_seq("0123", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
    @(negedge clk);
    chk("mid_mem_req_before", 0, 64'(mrq[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_mem_req_after", 0, 64'(mrq[0]), 64'd0);
    chk("mid_mem_state", 0, 64'(st[0]), 64'd0);
    chk("mid_mem_retire", 0, rc_of(0), 64'd0);
    chk("mid_mem_pc_we", 0, 64'(pcw[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 16 ALU ops: 4-bit counter wraps, wider ones reach 16
    for (int n = 0; n < 16; n++) run_seq("01240", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, -1);
    chk("wrap_cnt4", 0, rc_of(0), 64'd0);
    chk("wrap_cnt32", 1, rc_of(1), 64'd16);
    chk("wrap_cnt8", 2, rc_of(2), 64'd16);

    // Illegal wins over is_load; HALT holds 20 cycles with no requests
    s = "01";
    for (int n = 0; n < 20; n++) s = {s, "5"};
    run_seq(s, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1);
    chk("halt_fetch_req", 0, 64'(c_fr), 64'd1);
    chk("halt_mem_req", 0, 64'(c_mreq), 64'd0);
    chk("halt_pc_we", 0, 64'(c_pc), 64'd0);
    chk("halt_cycles", 0, 64'(c_halt), 64'd20);
    chk("halt_retire", 0, rc_of(0), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("halt_rst_state", 0, 64'(st[0]), 64'd0);
    chk("halt_rst_halted", 0, 64'(hlt[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic, occasional resets; the per-cycle compare does the checking
    for (int n = 0; n < 3000; n++) begin
      fetch_ready = 1'($urandom_range(0, 1));
      mem_ready   = 1'($urandom_range(0, 1));
      if (ph[0] == 0 || ph[0] == 5) begin
        is_load   = ($urandom_range(0, 3) == 0);
        is_store  = ($urandom_range(0, 3) == 0);
        is_muldiv = ($urandom_range(0, 2) == 0);
        writes_rd = 1'($urandom_range(0, 1));
        illegal   = ($urandom_range(0, 47) == 0);
      end
      do_rst = ($urandom_range(0, 199) == 0) || (ph[0] == 5 && $urandom_range(0, 7) == 0);
      if (do_rst) begin
        #7 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
